// File: rtl/vis_stream_ctrl.sv
// vis_stream_ctrl
//   Reads one visibility frame from the correlator bus interface and serialises
//   it onto an 8-bit AXI-stream toward the USB bulk IN endpoint. Each frame is
//   MAGIC (2 bytes, MSB first), seq (2 bytes, MSB first), then VISIBS words of
//   8 bytes each ({re, im}, most significant byte first). tlast marks the final
//   byte. Frames requested while busy are counted in a saturating drop counter.
//
// Ports
//   clock, reset_n            clock, async active-low reset
//   enable_i, frame_i         readout enable, new-frame pulse
//   busy_o                    FSM not idle
//   bus_ready_o/valid_i/last_i, bus_revis_i, bus_imvis_i   correlator readout
//   m_tvalid_o/tready_i/tlast_o/tdata_o                    byte stream out
//   seq_o                     sequence number of current / most recent frame
//   dropped_o                 overlapping frame requests (saturating)
//   err_o                     sticky: bus_last_i disagreed with word count
module vis_stream_ctrl #(
    parameter int          ACCUM  = 32,
    parameter int          VISIBS = 276,
    parameter int          VBITS  = 9,
    parameter logic [15:0] MAGIC  = 16'hA55A
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             frame_i,
    output logic             busy_o,
    output logic             bus_ready_o,
    input  logic             bus_valid_i,
    input  logic             bus_last_i,
    input  logic [ACCUM-1:0] bus_revis_i,
    input  logic [ACCUM-1:0] bus_imvis_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [7:0]       m_tdata_o,
    output logic [15:0]      seq_o,
    output logic [7:0]       dropped_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, HDR, REQ, SEND} state_t;

    localparam logic [VBITS-1:0] LAST_WORD = VBITS'(VISIBS - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [VBITS-1:0]   cnt_q, cnt_d;
    logic [2*ACCUM-1:0] shr_q, shr_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               ready_q, ready_d;
    logic [15:0]        seq_q, seq_d;
    logic [7:0]         drop_q, drop_d;
    logic               err_q, err_d;

    logic last_word, xfer, take;

    assign last_word = (cnt_q == LAST_WORD);
    assign xfer      = tvalid_q && m_tready_i;
    // ready_q is only ever high in REQ, so bus_valid_i elsewhere is ignored
    assign take      = ready_q && bus_valid_i;

    function automatic logic [7:0] hdr_byte(input logic [1:0] i, input logic [15:0] s);
        case (i)
            2'd0:    hdr_byte = MAGIC[15:8];
            2'd1:    hdr_byte = MAGIC[7:0];
            2'd2:    hdr_byte = s[15:8];
            default: hdr_byte = s[7:0];
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shr_d    = shr_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        ready_d  = ready_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                tvalid_d = 1'b0;
                ready_d  = 1'b0;
                if (frame_i && enable_i) begin
                    state_d = HDR;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end
            end
            HDR: begin
                // First HDR cycle loads byte 0; afterwards bytes stream back to back
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hdr_byte(idx_q[1:0], seq_q);
                end else if (m_tready_i) begin
                    if (idx_q == 3'd3) begin
                        tvalid_d = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = REQ;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tdata_d = hdr_byte(idx_q[1:0] + 2'd1, seq_q);
                    end
                end
            end
            REQ: begin
                if (take) begin
                    // Byte 0 goes straight to the output; the rest waits in shr
                    tdata_d  = bus_revis_i[ACCUM-1 -: 8];
                    shr_d    = {bus_revis_i[ACCUM-9:0], bus_imvis_i, 8'h00};
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    ready_d  = 1'b0;
                    idx_d    = 3'd0;
                    state_d  = SEND;
                    if (bus_last_i != last_word) err_d = 1'b1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == 3'd7) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        if (last_word) begin
                            state_d = IDLE;
                            seq_d   = seq_q + 16'd1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            ready_d = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tdata_d = shr_q[2*ACCUM-1 -: 8];
                        shr_d   = {shr_q[2*ACCUM-9:0], 8'h00};
                        tlast_d = (idx_q == 3'd6) && last_word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Overlap: includes the cycle of the final tlast transfer (still busy)
        if (frame_i && enable_i && (state_q != IDLE) && (drop_q != 8'hFF))
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shr_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            ready_q  <= 1'b0;
            seq_q    <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shr_q    <= shr_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            ready_q  <= ready_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign bus_ready_o = ready_q;
    assign m_tvalid_o  = tvalid_q;
    assign m_tlast_o   = tlast_q;
    assign m_tdata_o   = tdata_q;
    assign seq_o       = seq_q;
    assign dropped_o   = drop_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_vis_stream_ctrl.sv
// Directed bench for vis_stream_ctrl with VISIBS=2 (20-byte frames).
module tb_vis_stream_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable_i, frame_i, busy_o;
    logic        bus_ready_o, bus_valid_i, bus_last_i;
    logic [31:0] bus_revis_i, bus_imvis_i;
    logic        m_tvalid_o, m_tready_i, m_tlast_o;
    logic [7:0]  m_tdata_o;
    logic [15:0] seq_o;
    logic [7:0]  dropped_o;
    logic        err_o;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] qd[$];
    bit         ql[$];
    bit         pv, pr, pl;
    logic [7:0] pd;
    int         tb_wc = 0;
    bit         err_mode = 0;

    always #5 clock = ~clock;

    vis_stream_ctrl #(.ACCUM(32), .VISIBS(2), .VBITS(2), .MAGIC(16'hA55A)) dut (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i), .frame_i(frame_i),
        .busy_o(busy_o), .bus_ready_o(bus_ready_o), .bus_valid_i(bus_valid_i),
        .bus_last_i(bus_last_i), .bus_revis_i(bus_revis_i), .bus_imvis_i(bus_imvis_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
        .m_tdata_o(m_tdata_o), .seq_o(seq_o), .dropped_o(dropped_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word index of the next capture, used to drive bus_last_i
    always @(posedge clock) begin
        if (frame_i && enable_i && !busy_o) tb_wc <= 0;
        else if (bus_ready_o && bus_valid_i) tb_wc <= tb_wc + 1;
    end
    assign bus_last_i = err_mode ? (tb_wc == 0) : (tb_wc == 1);

    // Byte collector and hold-during-stall checker
    always @(negedge clock) begin
        #1;
        if (!reset_n) pv = 0;
        else begin
            if (pv && !pr) begin
                chk("stall_vld", m_tvalid_o, 1);
                chk("stall_dat", m_tdata_o, pd);
                chk("stall_last", m_tlast_o, pl);
            end
            if (m_tvalid_o && m_tready_i) begin
                qd.push_back(m_tdata_o);
                ql.push_back(m_tlast_o);
            end
            pv = m_tvalid_o; pr = m_tready_i; pd = m_tdata_o; pl = m_tlast_o;
        end
    end

    function automatic logic [7:0] exp_byte(input int i, input logic [15:0] s);
        logic [63:0] w;
        int k;
        w = 64'h1122334455667788;
        k = (i - 4) % 8;
        case (i)
            0: return 8'hA5;
            1: return 8'h5A;
            2: return s[15:8];
            3: return s[7:0];
            default: return 8'(w >> (56 - 8 * k));
        endcase
    endfunction

    task automatic check_frame(input int base, input logic [15:0] s);
        chk("frame_len", 64'(qd.size() - base), 20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < qd.size()) begin
                chk($sformatf("byte%0d", i), qd[base + i], exp_byte(i, s));
                chk($sformatf("tlast%0d", i), ql[base + i], (i == 19));
            end
        end
    endtask

    // mode 0: tready=1; mode 1: toggling tready with random 3-cycle stalls
    task automatic run_frame(input int mode, input int dup_at, input bit dup_last);
        int  cyc = 0;
        int  stall = 0;
        bit  done = 0;
        @(negedge clock); frame_i = 1; m_tready_i = 1;
        @(negedge clock); frame_i = 0;
        while (!done) begin
            if (mode == 0) m_tready_i = 1;
            else if (stall > 0) begin m_tready_i = 0; stall--; end
            else if ($urandom_range(0, 9) == 0) begin m_tready_i = 0; stall = 2; end
            else m_tready_i = ~cyc[0];
            #1;
            frame_i = (cyc == dup_at) || (dup_last && m_tvalid_o && m_tready_i && m_tlast_o);
            @(negedge clock);
            frame_i = 0;
            cyc++;
            if (!busy_o) done = 1;
            else if (cyc > 400) begin chk("timeout", 1, 0); done = 1; end
        end
        m_tready_i = 1;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_tvalid"}, m_tvalid_o, 0);
        chk({pfx, "_tlast"}, m_tlast_o, 0);
        chk({pfx, "_tdata"}, m_tdata_o, 0);
        chk({pfx, "_ready"}, bus_ready_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_seq"}, seq_o, 0);
        chk({pfx, "_drop"}, dropped_o, 0);
        chk({pfx, "_err"}, err_o, 0);
    endtask

    initial begin
        int  base;
        bit  found;
        reset_n = 0; enable_i = 1; frame_i = 0; m_tready_i = 1;
        bus_valid_i = 1; bus_revis_i = 32'h11223344; bus_imvis_i = 32'h55667788;
        repeat (3) @(negedge clock);
        check_zero("rst");
        reset_n = 1;

        // Plain frame, full throughput
        base = qd.size();
        run_frame(0, -1, 0);
        check_frame(base, 16'h0000);
        chk("f0_seq", seq_o, 1);
        chk("f0_busy", busy_o, 0);
        chk("f0_err", err_o, 0);

        // Backpressure
        base = qd.size();
        run_frame(1, -1, 0);
        check_frame(base, 16'h0001);
        chk("f1_seq", seq_o, 2);

        // Overlap during header
        base = qd.size();
        run_frame(0, 2, 0);
        check_frame(base, 16'h0002);
        chk("f2_drop", dropped_o, 1);
        chk("f2_seq", seq_o, 3);

        // Overlap on the final tlast cycle
        base = qd.size();
        run_frame(0, -1, 1);
        check_frame(base, 16'h0003);
        chk("f3_drop", dropped_o, 2);
        @(negedge clock);
        chk("f3_busy", busy_o, 0);
        chk("f3_seq", seq_o, 4);

        // bus_last on the wrong word
        chk("f4_err_pre", err_o, 0);
        err_mode = 1;
        base = qd.size();
        run_frame(0, -1, 0);
        err_mode = 0;
        check_frame(base, 16'h0004);
        chk("f4_err", err_o, 1);
        chk("f4_seq", seq_o, 5);

        // Reset during SEND byte 3 of word 0
        base = qd.size();
        found = 0;
        @(negedge clock); frame_i = 1;
        @(negedge clock); frame_i = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock); #2;
            if (qd.size() - base >= 8) found = 1;
        end
        chk("rst_wait", found, 1);
        chk("rst_pre_vld", m_tvalid_o, 1);
        reset_n = 0;
        #1;
        check_zero("arst");
        @(negedge clock);
        reset_n = 1;
        base = qd.size();
        run_frame(0, -1, 0);
        check_frame(base, 16'h0000);
        chk("f5_seq", seq_o, 1);

        // Disabled: frame_i ignored
        enable_i = 0;
        base = qd.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            frame_i = i[0];
            #2;
            chk("dis_ready", bus_ready_o, 0);
            chk("dis_busy", busy_o, 0);
        end
        @(negedge clock); frame_i = 0;
        repeat (3) @(negedge clock);
        chk("dis_bytes", 64'(qd.size() - base), 0);
        chk("dis_drop", dropped_o, 0);
        chk("dis_vld", m_tvalid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vis_stream_ctrl.md
Name: vis_stream_ctrl

Overview:
- Sequences visibility readout from the correlator's bus-side interface (32-bit real/imag words, valid/ready/last) and serialises each frame into an 8-bit AXI-stream.
- The stream feeds the USB bulk IN endpoint (s_axis of the ULPI bulk core).
- Prepends a 4-byte header carrying a frame sequence number, and terminates each frame with tlast.
- Counts frames dropped because a new frame arrived while readout was still busy.

Parameters:
- ACCUM, 32, visibility word width; fixed at 32 (8 bytes per visibility).
- VISIBS, 276, visibility words read per frame (24 antennas: 24*23/2).
- VBITS, 9, width of the word counter; must satisfy 2^VBITS >= VISIBS.
- MAGIC, 16'hA55A, header sync word, sent MSB first.

Ports:
- clock  in  1  system clock (axi_clk domain)
- reset_n  in  1  reset, asynchronous assert, active-low
- enable_i  in  1  readout enable; when low, frame_i is ignored
- frame_i  in  1  one-cycle pulse: a new visibility frame is ready in the correlator
- busy_o  out  1  high whenever the FSM is not in IDLE
- bus_ready_o  out  1  request for the next visibility word
- bus_valid_i  in  1  visibility word valid
- bus_last_i  in  1  correlator marks the final word of its frame
- bus_revis_i  in  32  real part
- bus_imvis_i  in  32  imaginary part
- m_tvalid_o  out  1  AXI-stream valid
- m_tready_i  in  1  AXI-stream ready
- m_tlast_o  out  1  last byte of the frame
- m_tdata_o  out  8  stream byte
- seq_o  out  16  sequence number of the current or most recent frame
- dropped_o  out  8  frames dropped; saturates at 8'hFF
- err_o  out  1  sticky: bus_last_i disagreed with the word count

Behaviour:
- Reset: the FSM goes to IDLE asynchronously and every output goes to 0 (seq_o=0, dropped_o=0, err_o=0, m_tvalid_o=0, bus_ready_o=0).
  - A packet interrupted by reset is truncated, with no tlast. This is accepted; the host resyncs on MAGIC.
- FSM states: IDLE, HDR, REQ, SEND.
- IDLE:
  - frame_i=1 and enable_i=1 -> HDR; byte index cleared, word counter cleared.
  - frame_i with enable_i=0 -> ignored, not counted.
- HDR: emits MAGIC[15:8], MAGIC[7:0], seq[15:8], seq[7:0]. After the 4th byte is accepted -> REQ.
- REQ:
  - bus_ready_o=1, m_tvalid_o=0.
  - On bus_valid_i && bus_ready_o: capture {revis, imvis} into a 64-bit shift register and go to SEND.
  - bus_ready_o is registered and falls in the cycle after capture, so exactly one word is taken per REQ visit.
- SEND:
  - Emits 8 bytes: revis[31:24] first through imvis[7:0] last.
  - After the 8th byte is accepted: if word count == VISIBS-1 -> IDLE, otherwise increment the count -> REQ.
  - m_tlast_o=1 only on the 8th byte of word VISIBS-1.
- AXI-stream rules:
  - A byte transfers when m_tvalid_o && m_tready_i.
  - While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o hold stable and m_tvalid_o does not drop.
  - Outputs are registered.
  - Latency: frame_i accepted at edge N -> m_tvalid_o=1 with MAGIC[15:8] after edge N+1.
- Frame length is 4 + 8*VISIBS bytes (2212 at the default).
- Sequence number: seq_o increments by 1 when a frame completes (last byte accepted), and wraps 16'hFFFF -> 0. The first frame after reset carries seq 0x0000.
- Overlap: frame_i=1 while busy_o=1 -> dropped_o increments, saturating; the current frame is unaffected.
  - frame_i in the same cycle as the final tlast transfer counts as dropped, because the FSM is still busy.
- Last check: at capture, err_o is set (sticky until reset) if bus_last_i != (count == VISIBS-1). The frame still ends on the count, never on bus_last_i.
- bus_valid_i outside REQ is ignored.

Test Plan:
- VISIBS=2, MAGIC=16'hA55A, tready=1, bus_valid=1, re=32'h11223344, im=32'h55667788 -> bytes A5 5A 00 00 11 22 33 44 55 66 77 88 11 22 33 44 55 66 77 88; tlast only on byte 20; busy_o low afterwards; seq_o=1.
- Same stimulus with m_tready_i toggling 1,0,1,0 and random 3-cycle stalls -> identical byte sequence; data and tlast stable across every stall; no byte duplicated or lost.
- Second frame_i pulse during HDR of frame 0 -> dropped_o=1; a later frame_i in IDLE produces a header with seq bytes 00 01.
- bus_last_i=1 on word 0 (VISIBS=2) -> err_o=1 from the cycle after capture; frame is still 20 bytes with tlast on byte 20.
- reset_n pulsed low during SEND byte 3 -> m_tvalid_o=0 and all outputs 0 without a clock edge; the next frame starts with A5 5A 00 00.
- enable_i=0 with frame_i pulses -> no stream traffic, bus_ready_o stays 0, dropped_o stays 0.
- 65536 frames with VISIBS=1 -> seq_o wraps to 0x0000.
